im_loader: RTL and testbench
============================

Name: im_loader

Overview:
- Write-side companion to the instruction memory. Receives a byte stream from a host link, assembles big-endian 32-bit MIPS instruction words and writes them sequentially into instruction memory.
- Provides write enable, word-aligned byte address and data. The memory indexes with addr[11:2].
- Holds the CPU (cpu_hold, gating IRWr) while loading, so fetch never reads a partially written program.

Parameters:
- DEPTH, 1024, instruction memory size in 32-bit words; maximum accepted word count.
- BASE_ADDR, 32'h0000_0000, byte address of the first written word; must be 4-byte aligned.

Ports:
- clk  input  1  system clock, all state updates on posedge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse: begin a new load session
- byte_valid  input  1  byte_data is valid this cycle; one byte consumed per high cycle
- byte_data  input  8  incoming stream byte
- im_we  output  1  instruction memory write enable, one-cycle pulse per word
- im_addr  output  32  byte address of the word being written (bits 1:0 always 0)
- im_wdata  output  32  assembled instruction word
- busy  output  1  session in progress (HDR or DATA state)
- cpu_hold  output  1  equals busy; CPU must keep IRWr low while high
- done  output  1  sticky: last load completed successfully
- err  output  1  sticky: last load rejected (count > DEPTH)
- words_loaded  output  11  words written in the current/last session

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE.
  - im_we=0, im_addr=BASE_ADDR, im_wdata=0.
  - busy=cpu_hold=0, done=0, err=0, words_loaded=0, byte counter=0.
- Stream format: 2-byte big-endian word count N, then 4*N bytes. Within each word the first byte goes to bits 31:24 and the last byte to bits 7:0.
- States:
  - IDLE: byte_valid ignored. On start: clear done, err, words_loaded; im_addr=BASE_ADDR; go to HDR.
  - HDR: first valid byte -> N[15:8]; second -> N[7:0]. On the second byte:
    - N==0 -> DONE.
    - N>DEPTH -> ERR.
    - otherwise -> DATA.
  - DATA: shift each valid byte into the assembly register and count bytes mod 4. On the 4th byte:
    - next cycle im_we=1 and im_wdata = assembled word (latency: 1 cycle after the edge sampling the 4th byte).
    - im_addr holds the current address during the im_we cycle, then increments by 4 on the following edge.
    - words_loaded increments with the write.
    - After the write of word N, go to DONE.
  - DONE: done=1, go to IDLE next cycle; done stays high until the next start.
  - ERR: err=1, no further writes, go to IDLE next cycle; err stays high until the next start.
- Handshake: no backpressure. A byte arriving in the same cycle as a pending im_we is still accepted, so sustained back-to-back byte_valid is legal.
- start while busy: ignored.
- Bytes after word N completes: ignored (state is DONE/IDLE).
- Address: wraps only by 32-bit arithmetic. Since N<=DEPTH, the final address is BASE_ADDR + 4*(N-1), within the memory.
- Reset mid-session: immediate abort, all outputs to reset values. A partially assembled word is never written.
- busy is high exactly in HDR and DATA, including the cycle im_we of the last word is asserted. It falls when DONE or ERR is entered.

Test Plan:
- Reset then idle bytes: byte_valid pulses with no start -> im_we never asserts; busy=0, done=0, im_addr=0.
- Basic load: start; stream 00 02 3C 08 00 10 8D 09 00 00 back-to-back ->
  - im_we at addr 0 with wdata 32'h3C080010;
  - im_we at addr 4 with wdata 32'h8D090000;
  - done=1, words_loaded=2, busy/cpu_hold high throughout, low after.
- Zero count: start; 00 00 -> no im_we, done=1 two cycles after the second byte, words_loaded=0.
- Oversize: start; 04 01 (N=1025) -> err=1, done=0, no im_we; subsequent bytes ignored.
- Gapped stream and extra start: bytes with random 0-3 idle cycles, plus a start pulse mid-DATA -> identical writes to the basic load; the start is ignored.
- Reset mid-word: after 2 data bytes of word 0, pulse rst_n low asynchronously (not clock aligned) -> outputs reset immediately, no write. A new session writes from BASE_ADDR again.

Source files
------------

// File: rtl/im_loader.sv
// Instruction-memory loader: parses a count-prefixed big-endian byte stream and
// writes 32-bit words sequentially from BASE_ADDR, holding the CPU while busy.
module im_loader #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        busy,
  output logic        cpu_hold,
  output logic        done,
  output logic        err,
  output logic [10:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_DONE,
    S_ERR
  } state_t;

  state_t      state;
  logic        hdr_second;
  logic [7:0]  cnt_hi;
  logic [15:0] n_words;
  logic [1:0]  byte_cnt;
  logic [23:0] asm_p0;
  logic        take_p0;

  function automatic state_t hdr_next(input logic [15:0] n);
    if (n == 16'd0)
      return S_DONE;
    else if (int'(n) > DEPTH)
      return S_ERR;
    else
      return S_DATA;
  endfunction

  // Once the last word has been captured, trailing bytes are dropped even
  // though the write cycle itself still belongs to DATA.
  assign take_p0  = byte_valid && (state == S_DATA) &&
                    ({5'd0, words_loaded} != n_words);
  assign busy     = (state == S_HDR) || (state == S_DATA);
  assign cpu_hold = busy;

  // Byte assembly: the partial word needs no reset since byte_cnt gates its use.
  always_ff @(posedge clk) begin
    if (take_p0)
      asm_p0 <= {asm_p0[15:0], byte_data};
  end

  // Control and write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      hdr_second   <= 1'b0;
      cnt_hi       <= 8'd0;
      n_words      <= 16'd0;
      byte_cnt     <= 2'd0;
      im_we        <= 1'b0;
      im_addr      <= BASE_ADDR;
      im_wdata     <= 32'd0;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= 11'd0;
    end else begin
      im_we <= 1'b0;
      if (im_we)
        im_addr <= im_addr + 32'd4;

      case (state)
        S_IDLE: begin
          if (start) begin
            done         <= 1'b0;
            err          <= 1'b0;
            words_loaded <= 11'd0;
            im_addr      <= BASE_ADDR;
            hdr_second   <= 1'b0;
            byte_cnt     <= 2'd0;
            state        <= S_HDR;
          end
        end

        S_HDR: begin
          if (byte_valid) begin
            if (!hdr_second) begin
              cnt_hi     <= byte_data;
              hdr_second <= 1'b1;
            end else begin
              n_words    <= {cnt_hi, byte_data};
              hdr_second <= 1'b0;
              state      <= hdr_next({cnt_hi, byte_data});
            end
          end
        end

        S_DATA: begin
          if (take_p0) begin
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              im_we        <= 1'b1;
              im_wdata     <= {asm_p0, byte_data};
              words_loaded <= words_loaded + 11'd1;
            end
          end
          if (im_we && ({5'd0, words_loaded} == n_words))
            state <= S_DONE;
        end

        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end

        S_ERR: begin
          err   <= 1'b1;
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Scoreboard bench for im_loader: expected writes are queued as the stream is
// driven and popped whenever the loader pulses im_we.
module tb_im_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        im_we;
  logic [31:0] im_addr;
  logic [31:0] im_wdata;
  logic        busy;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [10:0] words_loaded;

  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] words[16];

  im_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .im_we        (im_we),
    .im_addr      (im_addr),
    .im_wdata     (im_wdata),
    .busy         (busy),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Write monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1 && im_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexp_we", {31'd0, im_we}, 32'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("we_addr", im_addr, e[63:32]);
        chk("we_data", im_wdata, e[31:0]);
        chk("we_hold", {30'd0, busy, cpu_hold}, 32'd3);
      end
    end
  end

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    start      = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("done_wait", {31'd0, done}, 32'd1);
  endtask

  task automatic load(input int n, input bit gapped, input bit mid_start);
    logic [15:0] n16;
    logic [31:0] w;
    n16 = 16'(n);
    pulse_start();
    for (int i = 0; i < n; i++)
      exp_q.push_back({32'(4 * i), words[i]});
    send(n16[15:8]);
    send(n16[7:0]);
    for (int i = 0; i < n; i++) begin
      w = words[i];
      for (int b = 0; b < 4; b++) begin
        if (gapped)
          idle($urandom_range(0, 3));
        if (mid_start && i == 1 && b == 0)
          start = 1'b1;
        send(w[31 - 8 * b -: 8]);
      end
      chk("we_lat", {31'd0, im_we}, 32'd1);
    end
    wait_done(50);
    chk("ld_words", {21'd0, words_loaded}, 32'(n));
    chk("ld_busy", {30'd0, busy, cpu_hold}, 32'd0);
    chk("ld_err", {31'd0, err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'd0;
    idle(3);
    chk("rst_we", {31'd0, im_we}, 32'd0);
    chk("rst_addr", im_addr, 32'd0);
    chk("rst_wdata", im_wdata, 32'd0);
    chk("rst_flags", {28'd0, busy, cpu_hold, done, err}, 32'd0);
    chk("rst_words", {21'd0, words_loaded}, 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Bytes with no session are ignored
    send(8'h00); send(8'h01); send(8'h12); send(8'h34);
    idle(3);
    chk("idle_flags", {28'd0, busy, cpu_hold, done, err}, 32'd0);
    chk("idle_addr", im_addr, 32'd0);

    // Basic two-word load, back to back
    words[0] = 32'h3C08_0010;
    words[1] = 32'h8D09_0000;
    load(2, 1'b0, 1'b0);
    idle(3);
    chk("done_sticky", {31'd0, done}, 32'd1);

    // Zero count
    pulse_start();
    chk("start_clr", {31'd0, done}, 32'd0);
    send(8'h00);
    send(8'h00);
    chk("zc_done_early", {31'd0, done}, 32'd0);
    chk("zc_busy", {31'd0, busy}, 32'd0);
    idle(1);
    chk("zc_done", {31'd0, done}, 32'd1);
    chk("zc_words", {21'd0, words_loaded}, 32'd0);

    // Oversize count (1025)
    pulse_start();
    send(8'h04);
    send(8'h01);
    idle(1);
    chk("ov_err", {31'd0, err}, 32'd1);
    chk("ov_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 6; i++)
      send(8'(8'h11 * (i + 1)));
    idle(3);
    chk("ov_err_hold", {31'd0, err}, 32'd1);
    chk("ov_busy", {31'd0, busy}, 32'd0);
    chk("ov_words", {21'd0, words_loaded}, 32'd0);

    // Gapped stream with a start pulse inside DATA
    load(2, 1'b1, 1'b1);
    idle(2);

    // Longer random load with trailing bytes that must be dropped
    for (int i = 0; i < 6; i++)
      words[i] = $urandom;
    load(6, 1'b1, 1'b0);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    idle(3);
    chk("tail_words", {21'd0, words_loaded}, 32'd6);

    // Asynchronous reset in the middle of word 0
    pulse_start();
    send(8'h00); send(8'h01);
    send(8'hAA); send(8'hBB);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_we", {31'd0, im_we}, 32'd0);
    chk("mid_addr", im_addr, 32'd0);
    chk("mid_flags", {28'd0, busy, cpu_hold, done, err}, 32'd0);
    chk("mid_words", {21'd0, words_loaded}, 32'd0);
    #4 rst_n = 1'b1;
    idle(2);
    words[0] = 32'h1122_3344;
    load(1, 1'b0, 1'b0);
    idle(3);

    chk("q_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
